// File: rtl/bcd_mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter_pkg
// Shared constants and helpers for the BCD clock-field counters.
//   BCD_DIGIT_W   : width of one packed BCD digit (4)
//   BCD_DIGIT_MAX : largest legal value of a single BCD digit (9)
//   pow10()       : 10**n as an elaboration-time constant
//   to_bcd()      : converts a decimal constant to packed BCD at elaboration,
//                   LS digit in bits [3:0]; caller truncates to its width
// -----------------------------------------------------------------------------
package bcd_mod_counter_pkg;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Only ever evaluated on parameters, so it folds to a constant and no
  // binary-to-BCD logic reaches the netlist.
  function automatic logic [63:0] to_bcd(input int value, input int digits);
    logic [63:0] r;
    int          v;
    r = '0;
    v = value;
    for (int i = 0; i < 16; i++) begin
      if (i < digits) begin
        r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter_if
// Control/data bundle of one BCD modulo counter stage.
//   en, up, load, load_val : driven by the controller (master)
//   q, co, err             : driven by the counter (slave)
// DIGITS must match the DIGITS of the counter that the bundle connects to.
// -----------------------------------------------------------------------------
interface bcd_mod_counter_if #(
  parameter int DIGITS = 2
) ();

  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   q;
  logic                  co;
  logic                  err;

  modport master (
    output en, up, load, load_val,
    input  q, co, err
  );

  modport slave (
    input  en, up, load, load_val,
    output q, co, err
  );

endinterface

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// Combinational next-value logic for one BCD digit of an up/down chain.
//   d      : current digit (0..9)
//   up     : 1 = increment, 0 = decrement
//   cin    : carry (up) / borrow (down) request from the lower digit
//   d_next : digit value after this step
//   cout   : carry/borrow passed to the next higher digit
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_mod_counter_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  input  logic                   up,
  input  logic                   cin,
  output logic [BCD_DIGIT_W-1:0] d_next,
  output logic                   cout
);

  always_comb begin
    d_next = d;
    cout   = 1'b0;
    if (cin) begin
      if (up) begin
        if (d >= BCD_DIGIT_MAX) begin
          d_next = '0;
          cout   = 1'b1;
        end else begin
          d_next = d + 4'd1;
        end
      end else begin
        if (d == '0) begin
          d_next = BCD_DIGIT_MAX;
          cout   = 1'b1;
        end else begin
          d_next = d - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
// Multi-digit packed-BCD modulo counter (0..MAX), up/down, with synchronous
// clear, validated parallel load and a registered one-cycle wrap pulse that
// feeds the en of the next cascaded stage.
//   clk  : rising-edge clock
//   ncr  : synchronous active-high clear (highest priority)
//   bus  : slave side of bcd_mod_counter_if
//          en/up/load/load_val in, q/co/err out
// Parameters: DIGITS (BCD digits), MAX (terminal decimal value).
// -----------------------------------------------------------------------------
module bcd_mod_counter
  import bcd_mod_counter_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int MAX    = 59
) (
  input  logic               clk,
  input  logic               ncr,
  bcd_mod_counter_if.slave   bus
);

  localparam int            W       = BCD_DIGIT_W * DIGITS;
  localparam logic [W-1:0]  MAX_BCD = W'(to_bcd(MAX, DIGITS));

  if (MAX < 1 || MAX > pow10(DIGITS) - 1) begin : g_bad_max
    $error("bcd_mod_counter: MAX out of range for DIGITS");
  end

  logic [W-1:0]  q_reg;
  logic          co_reg;
  logic          err_reg;
  logic [W-1:0]  q_step;
  logic [DIGITS:0] chain;
  logic          unused_top_carry;
  logic          at_max;
  logic          at_zero;
  logic          load_digits_ok;
  logic          load_ok;

  // Ripple chain: the LS digit always steps, higher digits step only when
  // the digit below wraps (9->0 up, 0->9 down).
  assign chain[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .d      (q_reg[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .up     (bus.up),
      .cin    (chain[i]),
      .d_next (q_step[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .cout   (chain[i+1])
    );
  end

  // The modulo wrap comes from the whole-value compares below, so the
  // chain's top carry is not needed.
  assign unused_top_carry = chain[DIGITS];

  assign at_max  = (q_reg == MAX_BCD);
  assign at_zero = (q_reg == '0);

  // With every digit at most 9, packed BCD orders exactly like the decimal
  // value, so a plain unsigned compare against MAX_BCD checks the range.
  always_comb begin
    load_digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_MAX)
        load_digits_ok = 1'b0;
    end
  end

  assign load_ok = load_digits_ok && (bus.load_val <= MAX_BCD);

  // Priority: clear, then load, then count, then hold. co and err are
  // rebuilt every edge so each is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (ncr) begin
      q_reg   <= '0;
      co_reg  <= 1'b0;
      err_reg <= 1'b0;
    end else if (bus.load) begin
      co_reg <= 1'b0;
      if (load_ok) begin
        q_reg   <= bus.load_val;
        err_reg <= 1'b0;
      end else begin
        err_reg <= 1'b1;
      end
    end else if (bus.en) begin
      err_reg <= 1'b0;
      if (bus.up && at_max) begin
        q_reg  <= '0;
        co_reg <= 1'b1;
      end else if (!bus.up && at_zero) begin
        q_reg  <= MAX_BCD;
        co_reg <= 1'b1;
      end else begin
        q_reg  <= q_step;
        co_reg <= 1'b0;
      end
    end else begin
      co_reg  <= 1'b0;
      err_reg <= 1'b0;
    end
  end

  assign bus.q   = q_reg;
  assign bus.co  = co_reg;
  assign bus.err = err_reg;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_mod_counter
// Three counters side by side: A (DIGITS=2, MAX=59), B (DIGITS=2, MAX=23)
// and C (DIGITS=1, MAX=2). Each is compared every cycle against an integer
// model of the counting rules; directed scenarios come first, then random
// traffic on all three at once.
// -----------------------------------------------------------------------------
module tb_bcd_mod_counter;

  logic clk;
  logic ncrA, ncrB, ncrC;

  bcd_mod_counter_if #(.DIGITS(2)) busA ();
  bcd_mod_counter_if #(.DIGITS(2)) busB ();
  bcd_mod_counter_if #(.DIGITS(1)) busC ();

  bcd_mod_counter #(.DIGITS(2), .MAX(59)) dutA (.clk(clk), .ncr(ncrA), .bus(busA));
  bcd_mod_counter #(.DIGITS(2), .MAX(23)) dutB (.clk(clk), .ncr(ncrB), .bus(busB));
  bcd_mod_counter #(.DIGITS(1), .MAX(2))  dutC (.clk(clk), .ncr(ncrC), .bus(busC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;

  // Per-counter stimulus and model state, index 0=A, 1=B, 2=C.
  int   mMax[3] = '{59, 23, 2};
  int   mDig[3] = '{2, 2, 1};
  int   mVal[3];
  bit   mCo[3];
  bit   mErr[3];
  bit   iNcr[3], iLoad[3], iEn[3], iUp[3];
  logic [7:0] iLv[3];

  function automatic logic [7:0] encode(input int val, input int digits);
    logic [7:0] r;
    int v;
    r = '0;
    v = val;
    for (int i = 0; i < digits; i++) begin
      r = r | (8'(v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input int id);
    int value, nib;
    bit ok;
    if (iNcr[id]) begin
      mVal[id] = 0; mCo[id] = 0; mErr[id] = 0;
    end else if (iLoad[id]) begin
      mCo[id] = 0;
      value = 0;
      ok = 1;
      for (int i = mDig[id] - 1; i >= 0; i--) begin
        nib = int'((iLv[id] >> (4 * i)) & 8'h0F);
        if (nib > 9) ok = 0;
        value = value * 10 + nib;
      end
      if (value > mMax[id]) ok = 0;
      if (ok) begin
        mVal[id] = value; mErr[id] = 0;
      end else begin
        mErr[id] = 1;
      end
    end else if (iEn[id]) begin
      mErr[id] = 0;
      if (iUp[id]) begin
        if (mVal[id] == mMax[id]) begin mVal[id] = 0; mCo[id] = 1; end
        else begin mVal[id] = mVal[id] + 1; mCo[id] = 0; end
      end else begin
        if (mVal[id] == 0) begin mVal[id] = mMax[id]; mCo[id] = 1; end
        else begin mVal[id] = mVal[id] - 1; mCo[id] = 0; end
      end
    end else begin
      mCo[id] = 0; mErr[id] = 0;
    end
  endtask

  // Drive all three counters from the input arrays, advance one edge and
  // compare every output against the model.
  task automatic clockOnce();
    ncrA = iNcr[0]; busA.load = iLoad[0]; busA.en = iEn[0]; busA.up = iUp[0]; busA.load_val = iLv[0];
    ncrB = iNcr[1]; busB.load = iLoad[1]; busB.en = iEn[1]; busB.up = iUp[1]; busB.load_val = iLv[1];
    ncrC = iNcr[2]; busC.load = iLoad[2]; busC.en = iEn[2]; busC.up = iUp[2]; busC.load_val = iLv[2][3:0];
    for (int id = 0; id < 3; id++) modelStep(id);
    @(posedge clk);
    #1;
    checkOutput("A.q",   32'(busA.q),   32'(encode(mVal[0], 2)));
    checkOutput("A.co",  32'(busA.co),  32'(mCo[0]));
    checkOutput("A.err", 32'(busA.err), 32'(mErr[0]));
    checkOutput("B.q",   32'(busB.q),   32'(encode(mVal[1], 2)));
    checkOutput("B.co",  32'(busB.co),  32'(mCo[1]));
    checkOutput("B.err", 32'(busB.err), 32'(mErr[1]));
    checkOutput("C.q",   32'(busC.q),   32'(encode(mVal[2], 1)));
    checkOutput("C.co",  32'(busC.co),  32'(mCo[2]));
    checkOutput("C.err", 32'(busC.err), 32'(mErr[2]));
    @(negedge clk);
  endtask

  task automatic idleAll();
    for (int id = 0; id < 3; id++) begin
      iNcr[id] = 0; iLoad[id] = 0; iEn[id] = 0; iUp[id] = 0; iLv[id] = '0;
    end
  endtask

  // One directed cycle on counter id; the other two sit idle.
  task automatic applyStimulus(input int id, input bit ncr, input bit load,
                               input bit en, input bit up, input logic [7:0] lv);
    idleAll();
    iNcr[id] = ncr; iLoad[id] = load; iEn[id] = en; iUp[id] = up; iLv[id] = lv;
    clockOnce();
  endtask

  initial begin
    idleAll();
    for (int id = 0; id < 3; id++) iNcr[id] = 1;
    clockOnce();

    // A: full up sweep 00..59 and wrap, crossing every 9->0 digit carry.
    for (int n = 0; n < 60; n++) applyStimulus(0, 0, 0, 1, 1, 8'h00);

    // B: wrap at 23, never 24.
    applyStimulus(1, 0, 1, 0, 0, 8'h19);
    for (int n = 0; n < 5; n++) applyStimulus(1, 0, 0, 1, 1, 8'h00);

    // B: down-wrap from 00 to 23, then BCD borrow 10 -> 09.
    applyStimulus(1, 1, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 1, 0, 8'h00);
    applyStimulus(1, 0, 0, 1, 0, 8'h00);
    applyStimulus(1, 0, 1, 0, 0, 8'h10);
    applyStimulus(1, 0, 0, 1, 0, 8'h00);

    // A: load validation.
    applyStimulus(0, 0, 1, 0, 0, 8'h45);
    applyStimulus(0, 0, 1, 0, 0, 8'h60);
    applyStimulus(0, 0, 0, 0, 0, 8'h00);
    applyStimulus(0, 0, 1, 1, 1, 8'h3A);

    // A: priority of clear over load/en, load over en.
    applyStimulus(0, 0, 1, 0, 0, 8'h37);
    applyStimulus(0, 1, 1, 1, 1, 8'h45);
    applyStimulus(0, 0, 1, 1, 1, 8'h12);

    // C: mod-3 digit with en toggled.
    applyStimulus(2, 0, 0, 1, 1, 8'h00);
    applyStimulus(2, 0, 0, 1, 1, 8'h00);
    applyStimulus(2, 0, 0, 1, 1, 8'h00);
    applyStimulus(2, 0, 0, 0, 1, 8'h00);
    applyStimulus(2, 0, 0, 0, 1, 8'h00);
    applyStimulus(2, 0, 0, 1, 1, 8'h00);

    // Random traffic on all three counters at once.
    for (int n = 0; n < 600; n++) begin
      for (int id = 0; id < 3; id++) begin
        iNcr[id]  = ($urandom_range(0, 31) == 0);
        iLoad[id] = ($urandom_range(0, 5) == 0);
        iEn[id]   = ($urandom_range(0, 3) != 0);
        iUp[id]   = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1)
          iLv[id] = encode($urandom_range(0, mMax[id] + 3), mDig[id]);
        else
          iLv[id] = 8'($urandom);
        if (mDig[id] == 1) iLv[id] = iLv[id] & 8'h0F;
      end
      clockOnce();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
